// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: entry layout,
// counter constants, saturating arithmetic and PC address split.
package bp_pkg;

    localparam int unsigned MAX_CNT_W = 4;
    localparam int unsigned MAX_TAG_W = 30;

    typedef logic [MAX_CNT_W-1:0] cnt_t;

    // Tags and counters are stored at maximum width; unused upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        cnt_t                 cnt;
    } bp_entry_t;

    // Weakly-not-taken (reset value) and weakly-taken (allocation value).
    function automatic cnt_t CNT_WNT(input int unsigned width);
        return cnt_t'((1 << (width - 1)) - 1);
    endfunction

    function automatic cnt_t CNT_WT(input int unsigned width);
        return cnt_t'(1 << (width - 1));
    endfunction

    function automatic cnt_t sat_inc(input cnt_t cnt, input int unsigned width);
        cnt_t max_v;
        max_v = cnt_t'((1 << width) - 1);
        return (cnt == max_v) ? cnt : cnt + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t cnt, input int unsigned width);
        if (width == 0) return cnt;
        return (cnt == '0) ? cnt : cnt - cnt_t'(1);
    endfunction

    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [MAX_TAG_W-1:0] tag_of(input logic [31:0] pc,
                                                    input int unsigned idx_w,
                                                    input int unsigned tag_w);
        return MAX_TAG_W'((pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1));
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Event counter that increments by one per qualifying cycle and holds at all-ones.
module bp_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational lookup from IF,
// registered training from ID, plus lookup/mispredict performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [31:0]       pred_target_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_mispred_i,
    input  logic              clear_i,
    output logic [PERF_W-1:0] perf_lookups_o,
    output logic [PERF_W-1:0] perf_mispred_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bp_entry_t tbl_d [ENTRIES];
    bp_entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0]     lk_idx, up_idx;
    logic [MAX_TAG_W-1:0] lk_tag, up_tag;
    bp_entry_t            lk_entry, up_entry;
    logic                 up_hit;
    logic                 unused_pc;

    assign lk_idx    = IDX_W'(idx_of(lookup_pc_i, IDX_W));
    assign up_idx    = IDX_W'(idx_of(upd_pc_i, IDX_W));
    assign lk_tag    = tag_of(lookup_pc_i, IDX_W, TAG_W);
    assign up_tag    = tag_of(upd_pc_i, IDX_W, TAG_W);
    assign unused_pc = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_entry      = tbl_q[lk_idx];
        pred_hit_o    = lk_entry.valid && (lk_entry.tag == lk_tag);
        pred_taken_o  = pred_hit_o && lk_entry.cnt[CNT_W-1];
        pred_target_o = pred_hit_o ? lk_entry.target : 32'd0;
    end

    always_comb begin
        tbl_d    = tbl_q;
        up_entry = tbl_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == up_tag);
        if (clear_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_d[i].valid = 1'b0;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    tbl_d[up_idx].cnt    = sat_inc(up_entry.cnt, CNT_W);
                    tbl_d[up_idx].target = upd_target_i;
                end else begin
                    tbl_d[up_idx].cnt = sat_dec(up_entry.cnt, CNT_W);
                end
            end else if (upd_taken_i) begin
                tbl_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target_i,
                                  cnt: CNT_WT(CNT_W)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT(CNT_W)};
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    bp_sat_counter #(
        .W (PERF_W)
    ) u_perf_lookups (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (lookup_en_i),
        .count_o (perf_lookups_o)
    );

    // Counted even when clear_i drops the table update.
    bp_sat_counter #(
        .W (PERF_W)
    ) u_perf_mispred (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (upd_valid_i && upd_mispred_i),
        .count_o (perf_mispred_o)
    );

endmodule
